// File: rtl/gpgpu_pkg.sv
// Shared GPGPU definitions used by the warp scheduler and its helpers.
// Holds the MP sizing constants and the warp/block identifier types so
// every block in the streaming multiprocessor agrees on their widths.
package gpgpu_pkg;

   localparam int NUM_WARPS     = 16;
   localparam int NUM_BLOCKS    = 8;
   localparam int WARPID_DEPTH  = $clog2(NUM_WARPS);
   localparam int BLOCKID_DEPTH = $clog2(NUM_BLOCKS);

   typedef logic [WARPID_DEPTH-1:0]  warp_id_t;
   typedef logic [BLOCKID_DEPTH-1:0] block_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set bit of req, searching upward from ptr+1 and wrapping
// modulo WIDTH, so the slot at ptr itself is considered last.
// Ports:
//   req       - request vector, bit i is requester i
//   ptr       - index of the most recently granted requester
//   grant     - at least one request is set
//   grant_idx - index of the winning requester (0 when grant is low)
module rr_arbiter #(
   parameter int WIDTH = 16,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             grant,
   output logic [IDX_W-1:0] grant_idx
);

   // Walk the WIDTH slots after ptr in rotating order; the first hit wins.
   always_comb begin
      int               s;
      logic [IDX_W-1:0] slot;
      grant     = 1'b0;
      grant_idx = '0;
      s         = 0;
      slot      = '0;
      for (int k = 1; k <= WIDTH; k++) begin
         s    = (int'(ptr) + k) % WIDTH;
         slot = IDX_W'(s);
         if (!grant && req[slot]) begin
            grant     = 1'b1;
            grant_idx = slot;
         end
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// Per-MP warp scheduler.
// Grants one ready warp per cycle into the pipeline using round-robin order
// over all warp slots, and releases block-level BAR barriers once every live
// warp of a block has arrived.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   ready      - per-warp ready flags
//   valid      - per-warp valid (slot occupied) flags
//   warp_bid   - block ID owning each warp slot
//   stall      - pipeline cannot take a warp this cycle
//   bar_arrive - one warp of block bar_bid executed BAR this cycle
//   bar_bid    - block ID of the arriving warp
//   enter      - a warp is granted this cycle (combinational)
//   enter_id   - granted warp slot (combinational)
//   bar_rst    - one-cycle barrier release pulse
//   bar_id     - block being released
module warp_scheduler
   import gpgpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WARPS-1:0] ready,
   input  logic [NUM_WARPS-1:0] valid,
   input  block_id_t            warp_bid [NUM_WARPS],
   input  logic                 stall,
   input  logic                 bar_arrive,
   input  block_id_t            bar_bid,
   output logic                 enter,
   output warp_id_t             enter_id,
   output logic                 bar_rst,
   output block_id_t            bar_id
);

   localparam int CNT_W = WARPID_DEPTH + 1;
   typedef logic [CNT_W-1:0] cnt_t;

   logic [NUM_WARPS-1:0]  cand;
   logic                  arb_any;
   warp_id_t              arb_idx;
   warp_id_t              rr_ptr;
   cnt_t                  live_cnt [NUM_BLOCKS];
   cnt_t                  arr_cnt  [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] rel_hit;
   logic                  rel_any;
   block_id_t             rel_bid;

   // Issue arbiter: the grant is combinational so a warp enters the pipeline
   // in the same cycle it is picked.
   assign cand = ready & valid;

   rr_arbiter #(
      .WIDTH (NUM_WARPS),
      .IDX_W (WARPID_DEPTH)
   ) u_issue_arb (
      .req       (cand),
      .ptr       (rr_ptr),
      .grant     (arb_any),
      .grant_idx (arb_idx)
   );

   assign enter    = ~stall & arb_any;
   assign enter_id = arb_idx;

   // Pointer remembers the last granted slot; reset value makes the first
   // search begin at slot 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr <= warp_id_t'(NUM_WARPS - 1);
      end else if (enter) begin
         rr_ptr <= enter_id;
      end
   end

   // Number of currently valid warps belonging to each block.
   always_comb begin
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         live_cnt[b] = '0;
      end
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            if (valid[i] && warp_bid[i] == block_id_t'(b)) begin
               live_cnt[b] = live_cnt[b] + cnt_t'(1);
            end
         end
      end
   end

   // A block is satisfied once its arrivals reach its live warp count. Using
   // >= lets warps that exit mid-barrier, or a block with no live warps left,
   // still release the ones that are waiting.
   always_comb begin
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         rel_hit[b] = (arr_cnt[b] != '0) && (arr_cnt[b] >= live_cnt[b]);
      end
   end

   // Priority encoder: lowest satisfied block is released first, the others
   // stay satisfied and go out on later cycles.
   always_comb begin
      rel_any = |rel_hit;
      rel_bid = '0;
      for (int b = NUM_BLOCKS - 1; b >= 0; b--) begin
         if (rel_hit[b]) begin
            rel_bid = block_id_t'(b);
         end
      end
   end

   // Registered release pulse and per-block arrival counters. An arrival for
   // the block being released lands after the clear, so it opens the next
   // barrier generation with a count of one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int b = 0; b < NUM_BLOCKS; b++) begin
            arr_cnt[b] <= '0;
         end
         bar_rst <= 1'b0;
         bar_id  <= '0;
      end else begin
         bar_rst <= rel_any;
         if (rel_any) begin
            bar_id <= rel_bid;
         end
         for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (rel_any && rel_bid == block_id_t'(b)) begin
               arr_cnt[b] <= (bar_arrive && bar_bid == block_id_t'(b)) ? cnt_t'(1) : '0;
            end else if (bar_arrive && bar_bid == block_id_t'(b)) begin
               arr_cnt[b] <= arr_cnt[b] + cnt_t'(1);
            end
         end
      end
   end

endmodule
